// File: rtl/ram_port_arbiter_pkg.sv
// Shared types for the RAM port arbiter: RAM word, RAM handshake state and arbiter FSM state.
package ram_port_arbiter_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'b00,
      BUSY   = 2'b01,
      ACCESS = 2'b10,
      ERROR  = 2'b11
   } ramstate_t;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_t;

endpackage

// File: rtl/ram_port_arbiter_rr_picker.sv
// Rotating-priority encoder: returns the first asserted request scanning ptr, ptr+1, ... (mod NREQ).
module rr_picker #(
   parameter  int NREQ = 4,
   localparam int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [IW-1:0]   gnt_idx,
   output logic            any
);

   // One extra bit so ptr + offset never overflows before the explicit wrap.
   localparam logic [IW:0] NREQ_W = (IW+1)'(NREQ);

   logic [IW:0]   sum;
   logic [IW-1:0] idx;

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      gnt_idx = '0;
      any     = 1'b0;
      sum     = '0;
      idx     = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!any) begin
            sum = {1'b0, ptr} + (IW+1)'(k);
            if (sum >= NREQ_W) begin
               sum = sum - NREQ_W;
            end
            idx = sum[IW-1:0];
            if (req[idx]) begin
               any     = 1'b1;
               gnt_idx = idx;
            end
         end
      end
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port among NREQ requesters, with burst lock,
// per-transaction timeout watchdog and a sticky error flag.
module ram_port_arbiter
   import ram_port_arbiter_pkg::*;
#(
   parameter  int NREQ    = 4,
   parameter  int TIMEOUT = 64,
   localparam int IW      = $clog2(NREQ),
   localparam int CW      = $clog2(TIMEOUT+1)
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic [NREQ-1:0]        req_ren,
   input  logic [NREQ-1:0]        req_wen,
   input  logic [NREQ-1:0]        req_lock,
   input  logic [NREQ-1:0][31:0]  req_addr,
   input  logic [NREQ-1:0][31:0]  req_store,
   output logic [NREQ-1:0]        req_wait,
   output logic [NREQ-1:0][31:0]  req_load,
   output logic                   ramREN,
   output logic                   ramWEN,
   output logic [31:0]            ramaddr,
   output logic [31:0]            ramstore,
   input  logic [31:0]            ramload,
   input  ramstate_t              ramstate,
   output logic [IW-1:0]          grant_id,
   output logic                   err_flag
);

   arb_state_t      state;
   logic [IW-1:0]   ptr;
   logic [IW-1:0]   ptr_next;
   logic [CW-1:0]   cnt;
   logic [IW-1:0]   pick_idx;
   logic            pick_any;
   logic            g_active;
   logic            g_access;
   logic            timeout_hit;
   logic [NREQ-1:0] active;

   assign active      = req_ren | req_wen;
   assign g_active    = active[grant_id];
   assign g_access    = (ramstate == ACCESS);
   assign timeout_hit = (cnt == CW'(TIMEOUT-1)) && !g_access;
   // The just-served requester drops to lowest priority.
   assign ptr_next    = (grant_id == IW'(NREQ-1)) ? '0 : grant_id + IW'(1);

   rr_picker #(.NREQ(NREQ)) u_picker (
      .req     (active),
      .ptr     (ptr),
      .gnt_idx (pick_idx),
      .any     (pick_any)
   );

   // NOTE: registered state uses non-blocking assignments so all updates see pre-edge values.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= ARB_IDLE;
         ptr      <= '0;
         grant_id <= '0;
         cnt      <= '0;
         err_flag <= 1'b0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (pick_any) begin
                  grant_id <= pick_idx;
                  cnt      <= '0;
                  state    <= ARB_BUSY;
               end
            end
            ARB_BUSY: begin
               cnt <= cnt + CW'(1);
               if (ramstate == ERROR) begin
                  err_flag <= 1'b1;
                  ptr      <= ptr_next;
                  state    <= ARB_IDLE;
               end else if (timeout_hit) begin
                  err_flag <= 1'b1;
                  ptr      <= ptr_next;
                  state    <= ARB_IDLE;
               end else if (g_access && req_lock[grant_id] && g_active) begin
                  // Burst continues on the next word without an idle bubble.
                  cnt <= '0;
               end else if (g_access || !g_active) begin
                  ptr   <= ptr_next;
                  state <= ARB_IDLE;
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      req_wait = '1;
      req_load = '0;
      if (state == ARB_BUSY) begin
         ramWEN             = req_wen[grant_id];
         ramREN             = req_ren[grant_id] & ~req_wen[grant_id];
         ramaddr            = req_addr[grant_id];
         ramstore           = req_store[grant_id];
         req_load[grant_id] = ramload;
         req_wait[grant_id] = !g_access;
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed vector table, hand-written corner sequences
// and randomized traffic against a transaction-level reference model.
module tb_ram_port_arbiter;
   import ram_port_arbiter_pkg::*;

   localparam int NREQ    = 4;
   localparam int TIMEOUT = 64;
   localparam int IW      = 2;
   localparam int W       = NREQ*32;

   logic                  CLK = 1'b0;
   logic                  RST;
   logic [NREQ-1:0]       req_ren, req_wen, req_lock;
   logic [NREQ-1:0][31:0] req_addr, req_store;
   logic [NREQ-1:0]       req_wait;
   logic [NREQ-1:0][31:0] req_load;
   logic                  ramREN, ramWEN;
   logic [31:0]           ramaddr, ramstore, ramload;
   ramstate_t             ramstate;
   logic [IW-1:0]         grant_id;
   logic                  err_flag;

   ram_port_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
      .CLK(CLK), .RST(RST),
      .req_ren(req_ren), .req_wen(req_wen), .req_lock(req_lock),
      .req_addr(req_addr), .req_store(req_store),
      .req_wait(req_wait), .req_load(req_load),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate),
      .grant_id(grant_id), .err_flag(err_flag)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_err    = 0;

   // Reference model: who owns the port, for how long, and who is next in line.
   bit m_busy;
   int m_g, m_ptr, m_cnt;
   bit m_err;

   typedef struct {
      logic [3:0]  ren, wen, lock;
      ramstate_t   rs;
      logic        exp_ren, exp_wen;
      logic [3:0]  exp_wait;
      logic [1:0]  exp_gid;
      logic [31:0] exp_addr;
      logic        exp_err;
   } vec_t;

   vec_t tbl[$];

   logic [31:0] base_addr [NREQ] = '{32'h0000_0A00, 32'h0000_1100, 32'h0000_2200, 32'h0000_0100};
   logic [31:0] base_store[NREQ] = '{32'h5000_0000, 32'h5000_0001, 32'h5000_0002, 32'hDEAD_BEEF};

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [3:0] ren, input logic [3:0] wen, input logic [3:0] lock,
                               input ramstate_t rs, input logic eren, input logic ewen,
                               input logic [3:0] ewait, input logic [1:0] egid,
                               input logic [31:0] eaddr, input logic eerr);
      vec_t v;
      v.ren = ren; v.wen = wen; v.lock = lock; v.rs = rs;
      v.exp_ren = eren; v.exp_wen = ewen; v.exp_wait = ewait;
      v.exp_gid = egid; v.exp_addr = eaddr; v.exp_err = eerr;
      return v;
   endfunction

   task automatic model_update();
      bit act_g;
      int nxt;
      if (RST) begin
         m_busy = 0; m_g = 0; m_ptr = 0; m_cnt = 0; m_err = 0;
      end else if (!m_busy) begin
         for (int k = 0; k < NREQ; k++) begin
            int i = (m_ptr + k) % NREQ;
            if (!m_busy && (req_ren[i] || req_wen[i])) begin
               m_busy = 1; m_g = i; m_cnt = 0;
            end
         end
      end else begin
         act_g = req_ren[m_g] || req_wen[m_g];
         nxt   = (m_g + 1) % NREQ;
         if (ramstate == ERROR) begin
            m_err = 1; m_ptr = nxt; m_busy = 0;
         end else if (m_cnt == TIMEOUT-1 && ramstate != ACCESS) begin
            m_err = 1; m_ptr = nxt; m_busy = 0;
         end else if (ramstate == ACCESS && req_lock[m_g] && act_g) begin
            m_cnt = 0;
         end else if (ramstate == ACCESS || !act_g) begin
            m_ptr = nxt; m_busy = 0;
         end else begin
            m_cnt++;
         end
      end
   endtask

   task automatic check_model();
      logic            e_ren, e_wen;
      logic [31:0]     e_addr, e_store;
      logic [NREQ-1:0] e_wait;
      logic [W-1:0]    e_load;
      e_ren = 0; e_wen = 0; e_addr = '0; e_store = '0; e_wait = '1; e_load = '0;
      if (m_busy) begin
         e_wen   = req_wen[m_g];
         e_ren   = req_ren[m_g] && !req_wen[m_g];
         e_addr  = req_addr[m_g];
         e_store = req_store[m_g];
         e_wait[m_g] = (ramstate != ACCESS);
         e_load[m_g*32 +: 32] = ramload;
      end
      check("m.ramREN",   W'(ramREN),   W'(e_ren));
      check("m.ramWEN",   W'(ramWEN),   W'(e_wen));
      check("m.ramaddr",  W'(ramaddr),  W'(e_addr));
      check("m.ramstore", W'(ramstore), W'(e_store));
      check("m.req_wait", W'(req_wait), W'(e_wait));
      check("m.req_load", req_load,     e_load);
      check("m.grant_id", W'(grant_id), W'(m_g));
      check("m.err_flag", W'(err_flag), W'(m_err));
   endtask

   task automatic tick();
      @(posedge CLK);
      model_update();
      #1;
   endtask

   task automatic step();
      @(negedge CLK);
      check_model();
      tick();
   endtask

   initial begin
      int n, guard, r;

      RST = 1'b1; req_ren = '0; req_wen = '0; req_lock = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_addr[i] = base_addr[i]; req_store[i] = base_store[i];
      end
      ramload = 32'hCAFE_F00D; ramstate = FREE;
      m_busy = 0; m_g = 0; m_ptr = 0; m_cnt = 0; m_err = 0;

      // Reset held two cycles, requesters idle.
      tick(); tick();
      RST = 1'b0;
      @(negedge CLK);
      check("rst.ramREN",   W'(ramREN),   W'(0));
      check("rst.ramWEN",   W'(ramWEN),   W'(0));
      check("rst.req_wait", W'(req_wait), W'(4'b1111));
      check("rst.err_flag", W'(err_flag), W'(0));
      check("rst.grant_id", W'(grant_id), W'(0));
      check_model();
      tick();

      // Round robin between requesters 1 and 2, ACCESS on the third BUSY cycle.
      for (int rep = 0; rep < 2; rep++) begin
         tbl.push_back(mk(4'b0110, 4'b0, 4'b0, FREE,   0, 0, 4'b1111, (rep == 0) ? 2'd0 : 2'd2, 32'h0, 0));
         tbl.push_back(mk(4'b0110, 4'b0, 4'b0, BUSY,   1, 0, 4'b1111, 2'd1, 32'h1100, 0));
         tbl.push_back(mk(4'b0110, 4'b0, 4'b0, BUSY,   1, 0, 4'b1111, 2'd1, 32'h1100, 0));
         tbl.push_back(mk(4'b0110, 4'b0, 4'b0, ACCESS, 1, 0, 4'b1101, 2'd1, 32'h1100, 0));
         tbl.push_back(mk(4'b0110, 4'b0, 4'b0, FREE,   0, 0, 4'b1111, 2'd1, 32'h0, 0));
         tbl.push_back(mk(4'b0110, 4'b0, 4'b0, BUSY,   1, 0, 4'b1111, 2'd2, 32'h2200, 0));
         tbl.push_back(mk(4'b0110, 4'b0, 4'b0, BUSY,   1, 0, 4'b1111, 2'd2, 32'h2200, 0));
         tbl.push_back(mk(4'b0110, 4'b0, 4'b0, ACCESS, 1, 0, 4'b1011, 2'd2, 32'h2200, 0));
      end
      tbl.push_back(mk(4'b0000, 4'b0, 4'b0, FREE, 0, 0, 4'b1111, 2'd2, 32'h0, 0));
      // Requester 3 with read and write both set: write wins; pointer wraps to 0.
      tbl.push_back(mk(4'b1000, 4'b1000, 4'b0, FREE,   0, 0, 4'b1111, 2'd2, 32'h0, 0));
      tbl.push_back(mk(4'b1000, 4'b1000, 4'b0, BUSY,   0, 1, 4'b1111, 2'd3, 32'h0100, 0));
      tbl.push_back(mk(4'b1000, 4'b1000, 4'b0, ACCESS, 0, 1, 4'b0111, 2'd3, 32'h0100, 0));
      tbl.push_back(mk(4'b0000, 4'b0000, 4'b0, FREE,   0, 0, 4'b1111, 2'd3, 32'h0, 0));
      // Locked two-word burst for requester 0 while requester 2 waits.
      tbl.push_back(mk(4'b0101, 4'b0, 4'b0001, FREE,   0, 0, 4'b1111, 2'd3, 32'h0, 0));
      tbl.push_back(mk(4'b0101, 4'b0, 4'b0001, ACCESS, 1, 0, 4'b1110, 2'd0, 32'h0A00, 0));
      tbl.push_back(mk(4'b0101, 4'b0, 4'b0000, ACCESS, 1, 0, 4'b1110, 2'd0, 32'h0A00, 0));
      tbl.push_back(mk(4'b0100, 4'b0, 4'b0000, FREE,   0, 0, 4'b1111, 2'd0, 32'h0, 0));
      tbl.push_back(mk(4'b0100, 4'b0, 4'b0000, ACCESS, 1, 0, 4'b1011, 2'd2, 32'h2200, 0));
      tbl.push_back(mk(4'b0000, 4'b0, 4'b0000, FREE,   0, 0, 4'b1111, 2'd2, 32'h0, 0));
      // Requester 1 withdraws mid-transaction: enables drop in the same cycle.
      tbl.push_back(mk(4'b0010, 4'b0, 4'b0, FREE, 0, 0, 4'b1111, 2'd2, 32'h0, 0));
      tbl.push_back(mk(4'b0010, 4'b0, 4'b0, BUSY, 1, 0, 4'b1111, 2'd1, 32'h1100, 0));
      tbl.push_back(mk(4'b0000, 4'b0, 4'b0, BUSY, 0, 0, 4'b1111, 2'd1, 32'h1100, 0));
      tbl.push_back(mk(4'b0000, 4'b0, 4'b0, FREE, 0, 0, 4'b1111, 2'd1, 32'h0, 0));
      // RAM ERROR aborts and sets the sticky flag.
      tbl.push_back(mk(4'b0001, 4'b0, 4'b0, FREE,  0, 0, 4'b1111, 2'd1, 32'h0, 0));
      tbl.push_back(mk(4'b0001, 4'b0, 4'b0, ERROR, 1, 0, 4'b1111, 2'd0, 32'h0A00, 0));
      tbl.push_back(mk(4'b0000, 4'b0, 4'b0, FREE,  0, 0, 4'b1111, 2'd0, 32'h0, 1));

      foreach (tbl[i]) begin
         req_ren = tbl[i].ren; req_wen = tbl[i].wen; req_lock = tbl[i].lock;
         ramstate = tbl[i].rs; ramload = 32'h1234_0000 + 32'(i);
         @(negedge CLK);
         check($sformatf("vec%0d.ramREN", i),   W'(ramREN),   W'(tbl[i].exp_ren));
         check($sformatf("vec%0d.ramWEN", i),   W'(ramWEN),   W'(tbl[i].exp_wen));
         check($sformatf("vec%0d.req_wait", i), W'(req_wait), W'(tbl[i].exp_wait));
         check($sformatf("vec%0d.grant_id", i), W'(grant_id), W'(tbl[i].exp_gid));
         check($sformatf("vec%0d.ramaddr", i),  W'(ramaddr),  W'(tbl[i].exp_addr));
         check($sformatf("vec%0d.err_flag", i), W'(err_flag), W'(tbl[i].exp_err));
         check_model();
         tick();
      end

      // Timeout: RAM stuck BUSY, transaction aborted after exactly TIMEOUT BUSY cycles.
      RST = 1'b1; req_ren = '0; req_wen = '0; req_lock = '0; ramstate = FREE;
      tick();
      RST = 1'b0;
      req_ren = 4'b0100; ramstate = BUSY;
      step();
      n = 0; guard = 0;
      while (guard < 200) begin
         @(negedge CLK);
         if (!ramREN) break;
         n++;
         check_model();
         tick();
         guard++;
      end
      check("timeout.len",      W'(n),        W'(TIMEOUT));
      check("timeout.err_flag", W'(err_flag), W'(1));
      check_model();
      tick();
      for (int c = 0; c < 3; c++) begin
         @(negedge CLK);
         check("timeout.err_sticky", W'(err_flag), W'(1));
         check_model();
         tick();
      end
      req_ren = '0; ramstate = FREE;
      step(); step();

      // Reset mid-BUSY drops the transaction and re-arbitrates from index 0.
      RST = 1'b1;
      tick();
      RST = 1'b0;
      req_ren = 4'b0001; ramstate = ACCESS;
      step(); step();
      req_ren = 4'b1001; ramstate = BUSY;
      step();
      @(negedge CLK);
      check("midrst.pre_gid", W'(grant_id), W'(3));
      check_model();
      tick();
      step();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      @(negedge CLK);
      check("midrst.ramREN",   W'(ramREN),   W'(0));
      check("midrst.req_wait", W'(req_wait), W'(4'b1111));
      check("midrst.grant_id", W'(grant_id), W'(0));
      check("midrst.err_flag", W'(err_flag), W'(0));
      check_model();
      tick();
      @(negedge CLK);
      check("midrst.regrant",  W'(grant_id), W'(0));
      check("midrst.ramaddr",  W'(ramaddr),  W'(32'h0A00));
      check("midrst.ramREN1",  W'(ramREN),   W'(1));
      check_model();
      tick();

      // Randomized traffic against the reference model.
      for (int c = 0; c < 3000; c++) begin
         RST      = ($urandom_range(0, 99) == 0);
         req_ren  = NREQ'($urandom & $urandom);
         req_wen  = NREQ'($urandom & $urandom & $urandom);
         req_lock = NREQ'($urandom);
         for (int i = 0; i < NREQ; i++) begin
            req_addr[i]  = $urandom;
            req_store[i] = $urandom;
         end
         ramload = $urandom;
         r = $urandom_range(0, 99);
         if (r < 2)       ramstate = ERROR;
         else if (r < 35) ramstate = ACCESS;
         else if (r < 85) ramstate = BUSY;
         else             ramstate = FREE;
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
